// File: rtl/fsm_preparacion_cafe_if.sv
// Front-panel / datapath bundle for the coffee sequencer.
// master = panel and credit datapath side, slave = the sequencer itself.
interface fsm_preparacion_cafe_if;
  logic       tick_1hz;
  logic       coin_100;
  logic       coin_500;
  logic       sel_exp;
  logic       sel_lec;
  logic       sel_cap;
  logic       sel_cho;
  logic       azucar_req;
  logic       cancelar;
  logic [7:0] monto;
  logic       en_cont100;
  logic       en_cont500;
  logic       clr_credito;
  logic       devolver;
  logic [1:0] bebida;
  logic [3:0] estado;
  logic       productoListo;
  logic       agua;
  logic       cafe;
  logic       choco;
  logic       leche;
  logic       azucar;
  logic       bebidaLista;

  modport master (
    output tick_1hz, coin_100, coin_500, sel_exp, sel_lec, sel_cap, sel_cho,
           azucar_req, cancelar, monto,
    input  en_cont100, en_cont500, clr_credito, devolver, bebida, estado,
           productoListo, agua, cafe, choco, leche, azucar, bebidaLista
  );

  modport slave (
    input  tick_1hz, coin_100, coin_500, sel_exp, sel_lec, sel_cap, sel_cho,
           azucar_req, cancelar, monto,
    output en_cont100, en_cont500, clr_credito, devolver, bebida, estado,
           productoListo, agua, cafe, choco, leche, azucar, bebidaLista
  );
endinterface

// File: rtl/fsm_preparacion_cafe.sv
// Coffee machine sequencer: coin gating, selection, timed valve steps, ready phase.
// Optional feature: define CAFE_CANCEL_EN to enable the cancel/refund path.
module fsm_preparacion_cafe #(
  parameter int P_EXP       = 3,
  parameter int P_LEC       = 4,
  parameter int P_CAP       = 5,
  parameter int P_CHO       = 7,
  parameter int MAX_CREDITO = 11,
  parameter int T_LISTO     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fsm_preparacion_cafe_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CREDITO  = 4'd1,
    AGUA     = 4'd2,
    CAFE     = 4'd3,
    CHOCO    = 4'd4,
    LECHE    = 4'd5,
    AZUCAR   = 4'd6,
    LISTO    = 4'd7,
    DEVOLVER = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [1:0] bebida_q, bebida_d;
  logic       sugar_q, sugar_d;
  logic       en100_q, en100_d;
  logic       en500_q, en500_d;
  logic       clr_q, clr_d;
  logic       dev_q, dev_d;
  logic       listo_q, listo_d;
  logic       agua_q, agua_d;
  logic       cafe_q, cafe_d;
  logic       choco_q, choco_d;
  logic       leche_q, leche_d;
  logic       azucar_q, azucar_d;

  logic       coin100_ok, coin500_ok;
  logic       sel_any, sel_ok, cancel_hit;
  logic [1:0] sel_code;
  logic [7:0] sel_price;

  // Ticks spent in a step for a given recipe; zero means the step is skipped.
  function automatic logic [3:0] step_len(state_t s, logic [1:0] b, logic sug);
    logic [3:0] len;
    len = 4'd0;
    case (s)
      AGUA:   len = (b == 2'd2) ? 4'd1 : 4'd2;
      CAFE:   len = (b == 2'd0) ? 4'd3 : ((b == 2'd3) ? 4'd0 : 4'd2);
      CHOCO:  len = (b == 2'd3) ? 4'd3 : 4'd0;
      LECHE:  len = (b == 2'd0) ? 4'd0 : ((b == 2'd2) ? 4'd3 : 4'd2);
      AZUCAR: len = {3'b000, sug};
      LISTO:  len = 4'(T_LISTO);
      default: len = 4'd0;
    endcase
    return len;
  endfunction

  // First nonzero step strictly after s; checked from the back so the earliest wins.
  function automatic state_t next_step(state_t s, logic [1:0] b, logic sug);
    state_t n;
    n = LISTO;
    if (s < AZUCAR && step_len(AZUCAR, b, sug) != 4'd0) n = AZUCAR;
    if (s < LECHE  && step_len(LECHE,  b, sug) != 4'd0) n = LECHE;
    if (s < CHOCO  && step_len(CHOCO,  b, sug) != 4'd0) n = CHOCO;
    if (s < CAFE   && step_len(CAFE,   b, sug) != 4'd0) n = CAFE;
    if (s < AGUA   && step_len(AGUA,   b, sug) != 4'd0) n = AGUA;
    return n;
  endfunction

  assign coin100_ok = ({1'b0, bus.monto} + 9'd1) <= 9'(MAX_CREDITO);
  assign coin500_ok = ({1'b0, bus.monto} + 9'd5) <= 9'(MAX_CREDITO);
  assign sel_any    = bus.sel_exp | bus.sel_lec | bus.sel_cap | bus.sel_cho;

`ifdef CAFE_CANCEL_EN
  assign cancel_hit = bus.cancelar;
`else
  logic unused_cancelar;
  assign unused_cancelar = bus.cancelar;
  assign cancel_hit      = 1'b0;
`endif

  // Only the highest-priority selection is considered, then checked against its price.
  always_comb begin
    sel_code  = 2'd3;
    sel_price = 8'(P_CHO);
    if (bus.sel_exp) begin
      sel_code  = 2'd0;
      sel_price = 8'(P_EXP);
    end else if (bus.sel_lec) begin
      sel_code  = 2'd1;
      sel_price = 8'(P_LEC);
    end else if (bus.sel_cap) begin
      sel_code  = 2'd2;
      sel_price = 8'(P_CAP);
    end
    sel_ok = sel_any && (bus.monto >= sel_price);
  end

  always_comb begin
    state_d  = state_q;
    bebida_d = bebida_q;
    sugar_d  = sugar_q;
    en100_d  = 1'b0;
    en500_d  = 1'b0;
    clr_d    = 1'b0;
    timer_d  = timer_q;

    case (state_q)
      IDLE, CREDITO: begin
        if (state_q == CREDITO && cancel_hit) begin
          state_d = DEVOLVER;
        end else if (state_q == CREDITO && sel_any) begin
          if (sel_ok) begin
            bebida_d = sel_code;
            sugar_d  = bus.azucar_req;
            state_d  = next_step(CREDITO, sel_code, bus.azucar_req);
          end
        end else if (bus.coin_500) begin
          if (coin500_ok) begin
            en500_d = 1'b1;
            state_d = CREDITO;
          end
        end else if (bus.coin_100) begin
          if (coin100_ok) begin
            en100_d = 1'b1;
            state_d = CREDITO;
          end
        end
      end
      AGUA, CAFE, CHOCO, LECHE, AZUCAR, LISTO: begin
        if (bus.tick_1hz && timer_q == step_len(state_q, bebida_q, sugar_q) - 4'd1) begin
          if (state_q == LISTO) begin
            state_d = IDLE;
            clr_d   = 1'b1;
          end else begin
            state_d = next_step(state_q, bebida_q, sugar_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick landing on the entry edge is discarded by the clear.
    if (state_d != state_q)
      timer_d = 4'd0;
    else if (bus.tick_1hz && state_q != IDLE && state_q != CREDITO)
      timer_d = timer_q + 4'd1;

    dev_d    = (state_d == DEVOLVER);
    clr_d    = clr_d | dev_d;
    listo_d  = (state_d == LISTO);
    agua_d   = (state_d == AGUA);
    cafe_d   = (state_d == CAFE);
    choco_d  = (state_d == CHOCO);
    leche_d  = (state_d == LECHE);
    azucar_d = (state_d == AZUCAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= 4'd0;
      bebida_q <= 2'd0;
      sugar_q  <= 1'b0;
      en100_q  <= 1'b0;
      en500_q  <= 1'b0;
      clr_q    <= 1'b0;
      dev_q    <= 1'b0;
      listo_q  <= 1'b0;
      agua_q   <= 1'b0;
      cafe_q   <= 1'b0;
      choco_q  <= 1'b0;
      leche_q  <= 1'b0;
      azucar_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bebida_q <= bebida_d;
      sugar_q  <= sugar_d;
      en100_q  <= en100_d;
      en500_q  <= en500_d;
      clr_q    <= clr_d;
      dev_q    <= dev_d;
      listo_q  <= listo_d;
      agua_q   <= agua_d;
      cafe_q   <= cafe_d;
      choco_q  <= choco_d;
      leche_q  <= leche_d;
      azucar_q <= azucar_d;
    end
  end

  assign bus.estado        = state_q;
  assign bus.bebida        = bebida_q;
  assign bus.en_cont100    = en100_q;
  assign bus.en_cont500    = en500_q;
  assign bus.clr_credito   = clr_q;
  assign bus.devolver      = dev_q;
  assign bus.productoListo = listo_q;
  assign bus.bebidaLista   = listo_q;
  assign bus.agua          = agua_q;
  assign bus.cafe          = cafe_q;
  assign bus.choco         = choco_q;
  assign bus.leche         = leche_q;
  assign bus.azucar        = azucar_q;

endmodule
